dec_gpr_bank_xfer: RTL
======================

Name: dec_gpr_bank_xfer

Overview:
- Bank-switch sequencer for the banked GPR file.
- On a switch request it waits for the pipeline to drain, then reads a masked set of registers from the active bank into a local buffer.
- It then pulses the bank-id write and writes the buffered values into the same register numbers in the new bank.
- It is the agent that drives the register file's bank-id write interface and one read and one write port. It sits in dec beside the GPR file and holds decode while busy.

Parameters:
- GPR_BANKS, 2, number of register banks.
- GPR_BANKS_LOG2, 1, width of bank id.
- MAX_COPY, 4, buffer depth: maximum registers carried across a switch.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- switch_req  in  1  request bank switch; accepted when switch_req & ~busy.
- switch_bank  in  GPR_BANKS_LOG2  target bank, sampled at accept.
- copy_mask  in  31  bit j-1 set = carry xj (x1..x31), sampled at accept.
- pipe_idle  in  1  no GPR writes in flight.
- busy  out  1  sequencer not IDLE; stalls decode.
- switch_ack  out  1  one-cycle completion pulse.
- switch_err  out  1  qualifies switch_ack; request rejected.
- cur_bank  out  GPR_BANKS_LOG2  mirror of active bank.
- rden  out  1  GPR read enable.
- raddr  out  5  GPR read address.
- rd  in  32  GPR read data, combinational same cycle.
- wen  out  1  GPR write enable.
- waddr  out  5  GPR write address.
- wd  out  32  GPR write data.
- wen_bank_id  out  1  bank-id write strobe.
- wr_bank_id  out  GPR_BANKS_LOG2  new bank id.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; cur_bank=0; all outputs 0. Reset mid-operation aborts with no ack. The GPR file must be reset concurrently so its bank id is also 0.
- States: IDLE, DRAIN, READ, SWITCH, WRITE, DONE.
- IDLE: on accept, latch switch_bank, copy_mask, N=popcount(copy_mask).
  - Error if switch_bank>=GPR_BANKS, switch_bank==cur_bank, or N>MAX_COPY: go to DONE with err flag set.
  - Otherwise go to DRAIN.
- DRAIN: stay while pipe_idle=0; no timeout. On pipe_idle=1 go to READ if N>0, else SWITCH.
- READ: one register per cycle, ascending register number.
  - rden=1, raddr=next masked index; rd captured into buffer[k] at the edge.
  - After the Nth read go to SWITCH.
- SWITCH: one cycle with wen_bank_id=1 and wr_bank_id=latched bank. cur_bank updates at that edge. Then go to WRITE if N>0, else DONE.
- WRITE: one register per cycle, same ascending order. wen=1, waddr=index, wd=buffer[k]. After N writes go to DONE.
- DONE: switch_ack=1 for one cycle; switch_err=err flag. Then return to IDLE.
- busy=1 in every state except IDLE. switch_req while busy is ignored, not queued.
- Latency with pipe_idle=1 (accept edge = cycle 0): ack in cycle 2N+3. Error ack in cycle 1. Each extra DRAIN cycle adds 1.
- rden/wen/wen_bank_id are never asserted together. No GPR or bank change occurs on an error path.
- x0 is never addressed; copy_mask has no bit for x0.
- Mask scan uses a priority encoder on the remaining-mask register; the bit is cleared after each read. A copy of the latched mask is reused for WRITE.
- Buffer index and count width: clog2(MAX_COPY+1).

Decomposition:
- Package dec_gpr_bank_pkg holds:
  - state enum xfer_state_e;
  - function popcount31;
  - function first_set31 (returns 5-bit index, valid).
- One sub-module, dec_gpr_xfer_buf: MAX_COPY x 32 flop buffer with write pointer, read pointer and clear.

Test Plan:
- Reset, then req bank1 mask 0x0000_0006 (x2,x3), pipe_idle=1 → raddr 2,3 in cycles 2-3; wen_bank_id cycle 4 with id 1; writes x2,x3 with the captured values in cycles 5-6; ack cycle 7, err=0, cur_bank=1.
- Mask 0, bank1 → SWITCH cycle 2, ack cycle 3, no rden/wen.
- pipe_idle held low 5 cycles after accept → no rden until pipe_idle rises; ack delayed by 5 cycles.
- Invalid requests, each → ack+err in cycle 1, no strobes, cur_bank unchanged:
  - switch_bank == cur_bank;
  - mask 0x1F (N=5 > 4);
  - bank 2 with GPR_BANKS=2.
- rst asserted during WRITE → next cycle IDLE, busy=0, no ack, cur_bank=0. A new request then completes normally.
- switch_req held high continuously → second request accepted only on the cycle after ack (IDLE). Registers return to bank0 values.

Source files
------------

// File: rtl/dec_gpr_bank_xfer_pkg.sv
// Shared types and helpers for the GPR bank-switch sequencer.
// Holds the state encoding and the mask-scan functions.
package dec_gpr_bank_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_READ   = 3'd2,
        ST_SWITCH = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5
    } xfer_state_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] idx;
    } first_set_t;

    function automatic logic [4:0] popcount31(input logic [30:0] mask);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < 31; i++) begin
            cnt = cnt + {4'b0000, mask[i]};
        end
        return cnt;
    endfunction

    // Mask bit j-1 stands for register xj, so the returned index is already a register number.
    function automatic first_set_t first_set31(input logic [30:0] mask);
        first_set_t res;
        res = '0;
        for (int i = 30; i >= 0; i--) begin
            if (mask[i]) begin
                res.valid = 1'b1;
                res.idx   = 5'(i + 1);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dec_gpr_bank_xfer_if.sv
// Request/completion and GPR-port bundle between the bank-switch sequencer and its neighbours.
// The master side is the sequencer; the slave side is decode plus the GPR file.
interface dec_gpr_bank_xfer_if #(
    parameter int GPR_BANKS_LOG2 = 1
);
    logic                      switch_req;
    logic [GPR_BANKS_LOG2-1:0] switch_bank;
    logic [30:0]               copy_mask;
    logic                      pipe_idle;
    logic                      busy;
    logic                      switch_ack;
    logic                      switch_err;
    logic [GPR_BANKS_LOG2-1:0] cur_bank;
    logic                      rden;
    logic [4:0]                raddr;
    logic [31:0]               rd;
    logic                      wen;
    logic [4:0]                waddr;
    logic [31:0]               wd;
    logic                      wen_bank_id;
    logic [GPR_BANKS_LOG2-1:0] wr_bank_id;

    modport master (
        input  switch_req, switch_bank, copy_mask, pipe_idle, rd,
        output busy, switch_ack, switch_err, cur_bank,
        output rden, raddr, wen, waddr, wd, wen_bank_id, wr_bank_id
    );

    modport slave (
        output switch_req, switch_bank, copy_mask, pipe_idle, rd,
        input  busy, switch_ack, switch_err, cur_bank,
        input  rden, raddr, wen, waddr, wd, wen_bank_id, wr_bank_id
    );
endinterface

// File: rtl/dec_gpr_xfer_buf.sv
// Small flop buffer carrying register values across a bank switch.
// Filled in READ order and drained in the same order during WRITE.
module dec_gpr_xfer_buf #(
    parameter int MAX_COPY = 4,
    parameter int PTR_W    = $clog2(MAX_COPY + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic [31:0] pop_data
);

    logic [31:0]      mem [MAX_COPY];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && (wr_ptr < PTR_W'(MAX_COPY))) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop && (rd_ptr != wr_ptr)) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_COPY; i++) begin
            if (push && (wr_ptr == PTR_W'(i))) begin
                mem[i] <= push_data;
            end
        end
    end

    always_comb begin
        pop_data = '0;
        for (int i = 0; i < MAX_COPY; i++) begin
            if (rd_ptr == PTR_W'(i)) begin
                pop_data = mem[i];
            end
        end
    end

endmodule

// File: rtl/dec_gpr_bank_xfer.sv
// Bank-switch sequencer: drains the pipe, copies masked registers out of the old bank,
// flips the bank id, then writes the same registers into the new bank.
module dec_gpr_bank_xfer
    import dec_gpr_bank_pkg::*;
#(
    parameter int GPR_BANKS      = 2,
    parameter int GPR_BANKS_LOG2 = 1,
    parameter int MAX_COPY       = 4
) (
    input  logic                clk,
    input  logic                rst,
    dec_gpr_bank_xfer_if.master bus
);

    localparam int CNT_W = $clog2(MAX_COPY + 1);

    xfer_state_e               state;
    logic [GPR_BANKS_LOG2-1:0] bank_q;
    logic [GPR_BANKS_LOG2-1:0] cur_bank_q;
    logic [30:0]               mask_rem;
    logic [30:0]               mask_copy;
    logic [CNT_W-1:0]          n_q;
    logic [CNT_W-1:0]          left_q;
    logic                      err_q;

    logic [4:0]                req_pop;
    logic                      req_bad;
    logic                      accept;
    first_set_t                scan;
    logic [31:0]               buf_data;

    assign req_pop = popcount31(bus.copy_mask);
    assign req_bad = (32'(bus.switch_bank) >= GPR_BANKS)
                   || (bus.switch_bank == cur_bank_q)
                   || (32'(req_pop) > MAX_COPY);
    assign accept  = (state == ST_IDLE) && bus.switch_req;
    assign scan    = first_set31(mask_rem);

    // The remaining mask loses its lowest set bit per transfer, matching the scan order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            bank_q     <= '0;
            cur_bank_q <= '0;
            mask_rem   <= '0;
            mask_copy  <= '0;
            n_q        <= '0;
            left_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        bank_q    <= bus.switch_bank;
                        mask_rem  <= bus.copy_mask;
                        mask_copy <= bus.copy_mask;
                        n_q       <= CNT_W'(req_pop);
                        left_q    <= CNT_W'(req_pop);
                        err_q     <= req_bad;
                        state     <= req_bad ? ST_DONE : ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (bus.pipe_idle) begin
                        state <= (n_q != '0) ? ST_READ : ST_SWITCH;
                    end
                end
                ST_READ: begin
                    mask_rem <= mask_rem & (mask_rem - 31'd1);
                    left_q   <= left_q - CNT_W'(1);
                    if (left_q == CNT_W'(1)) begin
                        state <= ST_SWITCH;
                    end
                end
                ST_SWITCH: begin
                    cur_bank_q <= bank_q;
                    mask_rem   <= mask_copy;
                    left_q     <= n_q;
                    state      <= (n_q != '0) ? ST_WRITE : ST_DONE;
                end
                ST_WRITE: begin
                    mask_rem <= mask_rem & (mask_rem - 31'd1);
                    left_q   <= left_q - CNT_W'(1);
                    if (left_q == CNT_W'(1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    dec_gpr_xfer_buf #(
        .MAX_COPY (MAX_COPY),
        .PTR_W    (CNT_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .clr       (accept),
        .push      (state == ST_READ),
        .push_data (bus.rd),
        .pop       (state == ST_WRITE),
        .pop_data  (buf_data)
    );

    // Every GPR-side output is qualified by state so nothing leaks out of IDLE or reset.
    assign bus.busy        = (state != ST_IDLE);
    assign bus.switch_ack  = (state == ST_DONE);
    assign bus.switch_err  = (state == ST_DONE) && err_q;
    assign bus.cur_bank    = cur_bank_q;
    assign bus.rden        = (state == ST_READ);
    assign bus.raddr       = ((state == ST_READ) && scan.valid) ? scan.idx : 5'd0;
    assign bus.wen         = (state == ST_WRITE);
    assign bus.waddr       = ((state == ST_WRITE) && scan.valid) ? scan.idx : 5'd0;
    assign bus.wd          = (state == ST_WRITE) ? buf_data : 32'd0;
    assign bus.wen_bank_id = (state == ST_SWITCH);
    assign bus.wr_bank_id  = (state == ST_SWITCH) ? bank_q : '0;

endmodule
